// File: rtl/spi_reg_access_seq.sv
// Register request sequencer in front of spi_master_controller.
// Optional timeout on wait states: define SPI_SEQ_TIMEOUT_EN.
module spi_reg_access_seq #(
  parameter logic [3:0]  WR_OP       = 4'hB,
  parameter logic [3:0]  RD_OP       = 4'hA,
  parameter logic [3:0]  DEV_NIB     = 4'hB,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_vld_i,
  output logic        req_rdy_o,
  input  logic        req_wr_i,
  input  logic [7:0]  req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_vld_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] stream_data_tx_o,
  output logic        stream_data_tx_vld_o,
  input  logic        stream_data_tx_rdy_i,
  input  logic [31:0] stream_data_rx_i,
  input  logic        stream_data_rx_vld_i,
  output logic        stream_data_rx_rdy_o,
  input  logic        eot_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_EOT,
    WAIT_RX,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic        wr_q, wr_d;
  logic [15:0] rdata_q, rdata_d;
  logic        req_rdy_q, tx_vld_q, rx_rdy_q;
  logic        rsp_vld_q, busy_q;
  logic        to_hit;

  logic unused_rx_hi;
  assign unused_rx_hi = ^stream_data_rx_i[31:16];

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned CW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign to_hit = (cnt_q == CNT_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (state_q)
      SEND: if (stream_data_tx_rdy_i) cnt_d = '0;
      WAIT_EOT: begin
        cnt_d = cnt_q + 1'b1;
        if (eot_i)       err_d = 1'b0;
        else if (to_hit) err_d = 1'b1;
      end
      WAIT_RX: begin
        cnt_d = cnt_q + 1'b1;
        if (stream_data_rx_vld_i) err_d = 1'b0;
        else if (to_hit)          err_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign rsp_err_o = err_q;
`else
  assign to_hit    = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
      req_rdy_q <= 1'b0;
      tx_vld_q  <= 1'b0;
      rx_rdy_q  <= 1'b0;
      rsp_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      wr_q      <= wr_d;
      rdata_q   <= rdata_d;
      req_rdy_q <= (state_d == IDLE);
      tx_vld_q  <= (state_d == SEND);
      rx_rdy_q  <= (state_d == WAIT_RX);
      rsp_vld_q <= (state_d == RESP);
      busy_q    <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_vld_i) begin
          cmd_d = {req_wr_i ? WR_OP : RD_OP,
                   DEV_NIB,
                   req_addr_i,
                   req_wr_i ? req_wdata_i : 16'h0000};
          wr_d    = req_wr_i;
          state_d = SEND;
        end
      end
      SEND: begin
        if (stream_data_tx_rdy_i) begin
          cmd_d   = '0;
          state_d = wr_q ? WAIT_EOT : WAIT_RX;
        end
      end
      WAIT_EOT: begin
        if (eot_i || to_hit) begin
          rdata_d = '0;
          state_d = RESP;
        end
      end
      WAIT_RX: begin
        if (stream_data_rx_vld_i) begin
          rdata_d = stream_data_rx_i[15:0];
          state_d = RESP;
        end else if (to_hit) begin
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_rdy_o            = req_rdy_q;
  assign rsp_vld_o            = rsp_vld_q;
  assign rsp_rdata_o          = rdata_q;
  assign stream_data_tx_o     = cmd_q;
  assign stream_data_tx_vld_o = tx_vld_q;
  assign stream_data_rx_rdy_o = rx_rdy_q;
  assign busy_o               = busy_q;

endmodule

// File: doc/spi_reg_access_seq.md
Name: spi_reg_access_seq

Overview:
- Upstream request sequencer for spi_master_controller.
- Accepts single register read/write requests from a host-side bus and packs each into one 32-bit command word on the master's tx stream.
- Reads: consumes the master's rx stream word. Writes: waits for the master's end-of-transfer pulse.
- Each completed request returns exactly one response pulse with read data and an error flag.

Parameters:
- WR_OP, 4'hB, opcode nibble placed in cmd[31:28] for writes.
- RD_OP, 4'hA, opcode nibble placed in cmd[31:28] for reads.
- DEV_NIB, 4'hB, device/mode nibble placed in cmd[27:24] for all commands.
- TIMEOUT_CYC, 1024, cycles allowed in a wait state before error (SPI_SEQ_TIMEOUT_EN only).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset: one clock; asynchronous, active-low.
- req_vld_i  in  1  host request valid.
- req_rdy_o  out  1  sequencer ready for a request.
- req_wr_i  in  1  1 = write, 0 = read.
- req_addr_i  in  8  register address.
- req_wdata_i  in  16  write data (ignored for reads).
- rsp_vld_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  16  read data, valid with rsp_vld_o.
- rsp_err_o  out  1  timeout error, valid with rsp_vld_o.
- stream_data_tx_o  out  32  command word to master.
- stream_data_tx_vld_o  out  1  command valid.
- stream_data_tx_rdy_i  in  1  master accepts command.
- stream_data_rx_i  in  32  rx word from master.
- stream_data_rx_vld_i  in  1  rx word valid.
- stream_data_rx_rdy_o  out  1  sequencer accepts rx word.
- eot_i  in  1  master end-of-transfer pulse.
- busy_o  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0; stream_data_tx_o = 0; FSM = IDLE. Async assert, sync release.
- FSM states: IDLE, SEND, WAIT_EOT, WAIT_RX, RESP.
- IDLE:
  - req_rdy_o = 1.
  - On req_vld_i: register cmd = {req_wr_i ? WR_OP : RD_OP, DEV_NIB, req_addr_i, req_wr_i ? req_wdata_i : 16'h0000} and the op type; go to SEND.
- SEND:
  - stream_data_tx_vld_o = 1 with the registered cmd.
  - cmd is held stable until stream_data_tx_rdy_i; vld is never retracted before the handshake.
  - On handshake: go to WAIT_EOT for writes, WAIT_RX for reads.
- WAIT_EOT: on eot_i, go to RESP with rsp_err_o = 0 and rsp_rdata_o = 0.
- WAIT_RX:
  - stream_data_rx_rdy_o = 1 only in this state.
  - On stream_data_rx_vld_i: capture stream_data_rx_i[15:0] into rsp_rdata_o; go to RESP.
  - eot_i is ignored.
- RESP: rsp_vld_o = 1 for exactly one cycle; then IDLE. No response backpressure.
- Latency, write: request accepted at cycle 0 -> tx_vld at cycle 1; if tx_rdy is high in cycle 1 -> WAIT_EOT from cycle 2; eot_i at cycle N -> rsp_vld_o at cycle N+1.
- Latency, read: same path, with the rx handshake at cycle N -> rsp_vld_o at cycle N+1.
- Back-to-back: req_rdy_o is high the cycle after rsp_vld_o. Maximum throughput is one request per transfer.
- Stray inputs:
  - eot_i outside WAIT_EOT is ignored.
  - rx words outside WAIT_RX are not consumed (rx_rdy_o = 0).
- Mid-operation reset: FSM returns to IDLE and all outputs go to 0 immediately. No response is issued for the aborted request.
- rsp_rdata_o and rsp_err_o hold their last values after RESP until the next RESP.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- With the macro:
  - A cycle counter (width clog2(TIMEOUT_CYC)) clears on entry to WAIT_EOT or WAIT_RX and increments each cycle in those states.
  - If it reaches TIMEOUT_CYC-1 with no eot_i / rx handshake, go to RESP with rsp_err_o = 1 and rsp_rdata_o = 0.
  - An event arriving in the same cycle as expiry wins (rsp_err_o = 0).
  - SEND never times out.
- Without the macro: no counter; the wait states wait indefinitely; rsp_err_o is tied 0.

Test Plan:
- Write addr 0x10, wdata 0xA001; tx_rdy held high; eot_i after 40 cycles -> tx word 0xBB10A001 for exactly one cycle; rsp_vld_o one cycle after eot_i; rsp_err_o = 0.
- Read addr 0x10; rx word 0x0000_5A3C returned 30 cycles after tx handshake -> tx word 0xAB100000; rx_rdy_o high only in WAIT_RX; rsp_rdata_o = 0x5A3C.
- Hold tx_rdy low 10 cycles during SEND -> tx_vld stays high; tx word is stable; req_rdy_o = 0 throughout.
- Inject eot_i pulse and rx_vld while IDLE, then issue a read -> stray events ignored; the read completes only on its own rx handshake.
- SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16; read with no rx word -> rsp_vld_o with rsp_err_o = 1, rsp_rdata_o = 0, 16 cycles after entering WAIT_RX.
- Deassert rst_n_i while in WAIT_EOT -> outputs 0 asynchronously; no rsp_vld_o; a new write after release completes normally.
